pc_trace_buffer: RTL and testbench

PC_TRACE_BUFFER -- requirements
Module: pc_trace_buffer

---
 rtl/pc_trace_pkg.sv | 15 +
 rtl/trace_ram.sv | 27 ++
 rtl/pc_trace_buffer.sv | 147 ++++++++++++++
 tb/tb_pc_trace_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_trace_pkg.sv
// Shared types and default parameter values for the PC trace buffer.
package pc_trace_pkg;

  // Capture until frozen or halted, drain the trace oldest-first, then park.
  typedef enum logic [1:0] {
    StCapture = 2'd0,
    StDrain   = 2'd1,
    StDone    = 2'd2
  } trace_state_e;

  localparam int unsigned PcWDefault        = 64;
  localparam int unsigned DepthDefault      = 16;
  localparam int unsigned StallLimitDefault = 8;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: Depth x Width registers, one synchronous write port and one
// combinational read port. Contents are not reset.
module trace_ram #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 16,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [Aw-1:0]    i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [Aw-1:0]    i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  // Write the addressed entry on the rising edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pc_trace_buffer.sv
// Program-counter trace buffer: records PC samples into a circular buffer,
// detects a halt (PC stuck for STALL_LIMIT repeats), then drains oldest-first.
// Optional feature macro PC_TRACE_FILTER_EN: when defined only changed PCs are
// recorded; otherwise every valid sample in CAPTURE is recorded.
module pc_trace_buffer
  import pc_trace_pkg::*;
#(
  parameter int unsigned PC_W        = PcWDefault,
  parameter int unsigned DEPTH       = DepthDefault,
  parameter int unsigned STALL_LIMIT = StallLimitDefault
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PC_W-1:0]            pc_in,
  input  logic                       pc_valid,
  input  logic                       freeze,
  input  logic                       rd_ready,
  output logic [PC_W-1:0]            rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted,
  output logic                       overflow,
  output logic [31:0]                cycle_cnt
);

  localparam int unsigned Aw = $clog2(DEPTH);
  localparam int unsigned Cw = $clog2(DEPTH + 1);
  localparam int unsigned Sw = $clog2(STALL_LIMIT + 1);

  trace_state_e    r_state;
  logic [Aw-1:0]   r_wr_ptr;
  logic [Cw-1:0]   r_count;
  logic [Sw-1:0]   r_stall_cnt;
  logic            r_have_last;
  logic [PC_W-1:0] r_last_pc;
  logic            r_halted;
  logic            r_overflow;
  logic [31:0]     r_cycle_cnt;

  logic            w_capture;
  logic            w_new;
  logic            w_repeat;
  logic            w_halt_hit;
  logic            w_wr_en;
  logic            w_pop;
  logic [Aw-1:0]   w_rd_addr;
  logic [PC_W-1:0] w_rd_data;

  assign w_capture = (r_state == StCapture);
  assign w_new     = pc_valid && (!r_have_last || (pc_in != r_last_pc));
  assign w_repeat  = pc_valid && r_have_last && (pc_in == r_last_pc);
  // The repeat that reaches the limit declares the halt; it is the loop being
  // re-observed, so it is not recorded as a trace entry.
  assign w_halt_hit = w_capture && w_repeat && (r_stall_cnt == Sw'(STALL_LIMIT - 1));

`ifdef PC_TRACE_FILTER_EN
  assign w_wr_en = w_capture && w_new;
`else
  assign w_wr_en = w_capture && pc_valid && !w_halt_hit;
`endif

  assign rd_valid = (r_state == StDrain) && (r_count != '0);
  assign w_pop    = rd_valid && rd_ready;
  // Power-of-two depth: truncation gives the modulo; count == DEPTH maps to wr_ptr.
  assign w_rd_addr = r_wr_ptr - r_count[Aw-1:0];
  assign rd_data   = rd_valid ? w_rd_data : '0;

  assign count     = r_count;
  assign halted    = r_halted;
  assign overflow  = r_overflow;
  assign cycle_cnt = r_cycle_cnt;

  trace_ram #(
    .Width (PC_W),
    .Depth (DEPTH)
  ) u_trace_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (pc_in),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Capture/drain state machine with all bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StCapture;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_stall_cnt <= '0;
      r_have_last <= 1'b0;
      r_last_pc   <= '0;
      r_halted    <= 1'b0;
      r_overflow  <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      case (r_state)
        StCapture: begin
          if (r_cycle_cnt != '1) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
          end
          if (pc_valid) begin
            r_have_last <= 1'b1;
            r_last_pc   <= pc_in;
          end
          if (w_new) begin
            r_stall_cnt <= '0;
          end else if (w_repeat) begin
            r_stall_cnt <= r_stall_cnt + Sw'(1);
          end
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + Aw'(1);
            if (r_count == Cw'(DEPTH)) begin
              r_overflow <= 1'b1;
            end else begin
              r_count <= r_count + Cw'(1);
            end
          end
          if (w_halt_hit) begin
            r_halted <= 1'b1;
          end
          if (w_halt_hit || freeze) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_pop) begin
            r_count <= r_count - Cw'(1);
            if (r_count == Cw'(1)) begin
              r_state <= StDone;
            end
          end else if (r_count == '0) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StDone;
        end
        default: begin
          r_state <= StCapture;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Scoreboard bench for pc_trace_buffer (DEPTH=4, STALL_LIMIT=3). Expectations
// follow PC_TRACE_FILTER_EN when it is defined for the build.
module tb_pc_trace_buffer;

  localparam int unsigned PcW   = 64;
  localparam int unsigned Depth = 4;
  localparam int unsigned Limit = 3;

  logic           clk;
  logic           reset;
  logic [PcW-1:0] pc_in;
  logic           pc_valid;
  logic           freeze;
  logic           rd_ready;
  logic [PcW-1:0] rd_data;
  logic           rd_valid;
  logic [2:0]     count;
  logic           halted;
  logic           overflow;
  logic [31:0]    cycle_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [PcW-1:0] exp_q[$];

  pc_trace_buffer #(
    .PC_W        (PcW),
    .DEPTH       (Depth),
    .STALL_LIMIT (Limit)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .pc_valid  (pc_valid),
    .freeze    (freeze),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .halted    (halted),
    .overflow  (overflow),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    pc_valid = 1'b0;
    freeze   = 1'b0;
    rd_ready = 1'b0;
    pc_in    = '0;
    tick();
    tick();
  endtask

  // Feed a valid PC for one cycle.
  task automatic feed(input logic [PcW-1:0] pc);
    pc_valid = 1'b1;
    pc_in    = pc;
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic do_freeze();
    freeze = 1'b1;
    tick();
    freeze = 1'b0;
  endtask

  // Monitor: every accepted read is popped and checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_read: got 0x%0h expected no read at %0t", rd_data, $time);
        end else begin
          chk("rd_data_order", rd_data, exp_q.pop_front());
        end
      end else if (!rd_valid && !reset) begin
        chk("rd_data_zero_when_invalid", rd_data, 64'h0);
      end
    end
  end

  initial begin
    logic [PcW-1:0] pcs [6];
    int n_drain;

    // Reset state.
    do_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("rst_rd_data", rd_data, 64'h0);

    // Basic capture and drain of three PCs.
    reset = 1'b0;
    feed(64'h0);
    feed(64'h4);
    feed(64'h8);
    do_freeze();
    chk("a_count_after_freeze", 64'(count), 64'd3);
    chk("a_rd_valid", 64'(rd_valid), 64'd1);
    chk("a_cycle_cnt", 64'(cycle_cnt), 64'd4);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);
    rd_ready = 1'b1;
    tick();
    chk("a_count_2", 64'(count), 64'd2);
    tick();
    chk("a_count_1", 64'(count), 64'd1);
    tick();
    chk("a_count_0", 64'(count), 64'd0);
    chk("a_done_rd_valid", 64'(rd_valid), 64'd0);
    // DONE ignores capture inputs and does not count cycles.
    pc_valid = 1'b1;
    pc_in    = 64'h100;
    freeze   = 1'b1;
    tick();
    tick();
    pc_valid = 1'b0;
    freeze   = 1'b0;
    chk("a_done_count", 64'(count), 64'd0);
    chk("a_done_cycle_cnt", 64'(cycle_cnt), 64'd4);
    chk("a_done_rd_valid2", 64'(rd_valid), 64'd0);

    // Overflow: six samples into four entries.
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pcs[i] = 64'(i * 4);
    end
    for (int i = 0; i < 6; i++) begin
      feed(pcs[i]);
    end
    do_freeze();
    chk("b_overflow", 64'(overflow), 64'd1);
    chk("b_count", 64'(count), 64'd4);
    chk("b_halted", 64'(halted), 64'd0);
    exp_q.push_back(64'h8);
    exp_q.push_back(64'hC);
    exp_q.push_back(64'h10);
    exp_q.push_back(64'h14);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    chk("b_count_end", 64'(count), 64'd0);
    chk("b_rd_valid_end", 64'(rd_valid), 64'd0);

    // Halt detection after the third repeat of 0x4.
    do_reset();
    reset = 1'b0;
    feed(64'h0);
    feed(64'h4);
    feed(64'h4);
    feed(64'h4);
    chk("c_not_halted_yet", 64'(halted), 64'd0);
    feed(64'h4);
    chk("c_halted", 64'(halted), 64'd1);
    chk("c_rd_valid", 64'(rd_valid), 64'd1);
    chk("c_overflow", 64'(overflow), 64'd0);
`ifdef PC_TRACE_FILTER_EN
    chk("c_count", 64'(count), 64'd2);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    n_drain = 2;
`else
    chk("c_count", 64'(count), 64'd4);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h4);
    n_drain = 4;
`endif
    rd_ready = 1'b1;
    for (int i = 0; i < n_drain; i++) begin
      tick();
    end
    chk("c_count_end", 64'(count), 64'd0);

    // Back-pressure mid-drain.
    do_reset();
    reset = 1'b0;
    feed(64'h10);
    feed(64'h20);
    feed(64'h30);
    do_freeze();
    exp_q.push_back(64'h10);
    exp_q.push_back(64'h20);
    exp_q.push_back(64'h30);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_stall_rd_valid", 64'(rd_valid), 64'd1);
      chk("d_stall_rd_data", rd_data, 64'h20);
      chk("d_stall_count", 64'(count), 64'd2);
    end
    rd_ready = 1'b1;
    tick();
    tick();
    chk("d_count_end", 64'(count), 64'd0);

    // Reset in DRAIN with two entries left; reset beats freeze/pc_valid.
    do_reset();
    reset = 1'b0;
    feed(64'hA0);
    feed(64'hB0);
    feed(64'hC0);
    do_freeze();
    exp_q.push_back(64'hA0);
    rd_ready = 1'b1;
    tick();
    chk("e_count_before_reset", 64'(count), 64'd2);
    rd_ready = 1'b0;
    reset    = 1'b1;
    freeze   = 1'b1;
    pc_valid = 1'b1;
    pc_in    = 64'hD0;
    tick();
    chk("e_count", 64'(count), 64'd0);
    chk("e_rd_valid", 64'(rd_valid), 64'd0);
    chk("e_halted", 64'(halted), 64'd0);
    chk("e_cycle_cnt", 64'(cycle_cnt), 64'd0);
    reset    = 1'b0;
    freeze   = 1'b0;
    pc_valid = 1'b0;
    // Back in CAPTURE: cycle counter runs again.
    tick();
    tick();
    chk("e_capture_cycle_cnt", 64'(cycle_cnt), 64'd2);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
